// File: rtl/rom_fetch_bridge_pkg.sv
// Shared types for the ROM fetch bridge: FSM states, word-address width,
// buffer-entry layout and the byte-lane steering helper.
package rom_fetch_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_PREFETCH = 2'd2
    } state_e;

    localparam int ROM_AW_DEFAULT = 24;
    localparam int WORD_AW        = ROM_AW_DEFAULT - 1;
    // Tags are stored zero-extended to this width so one struct fits any ROM_AW <= 32.
    localparam int TAG_MAX_W      = 31;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [15:0]          data;
    } line_entry_t;

    // Word access passes the data through; byte access replicates the selected byte.
    function automatic logic [15:0] lane_sel(input logic [15:0] data,
                                             input logic        word,
                                             input logic        hi);
        if (word) begin
            lane_sel = data;
        end else if (hi) begin
            lane_sel = {data[15:8], data[15:8]};
        end else begin
            lane_sel = {data[7:0], data[7:0]};
        end
    endfunction

endpackage

// File: rtl/rom_fetch_bridge_line_buf.sv
// One buffer line (tag, valid, data) with its hit comparator.
module rom_line_buf
    import rom_fetch_bridge_pkg::*;
#(
    parameter int TAG_W = WORD_AW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inval_i,
    input  logic             wr_en_i,
    input  logic             wr_valid_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [15:0]      wr_data_i,
    input  logic [TAG_W-1:0] lookup_tag_i,
    output logic             hit_o,
    output logic [15:0]      data_o
);

    line_entry_t          entry_q;
    logic [TAG_MAX_W-1:0] wr_tag_ext_s;
    logic [TAG_MAX_W-1:0] lookup_ext_s;

    // Zero-extend tags to the stored width and compare for a hit.
    always_comb begin
        wr_tag_ext_s = TAG_MAX_W'(wr_tag_i);
        lookup_ext_s = TAG_MAX_W'(lookup_tag_i);
        hit_o        = entry_q.valid && (entry_q.tag == lookup_ext_s);
        data_o       = entry_q.data;
    end

    // Fill on write (valid as supplied by the caller); otherwise invalidate on request.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            entry_q <= '0;
        end else if (wr_en_i) begin
            entry_q.valid <= wr_valid_i;
            entry_q.tag   <= wr_tag_ext_s;
            entry_q.data  <= wr_data_i;
        end else if (inval_i) begin
            entry_q.valid <= 1'b0;
        end else begin
            entry_q <= entry_q;
        end
    end

endmodule

// File: rtl/rom_fetch_bridge.sv
// ROM fetch bridge: serves mapper ROM reads from a small line buffer and
// fetches missing words from the memory controller.
// Optional feature macro: ROM_PREFETCH_EN (second line + next-word prefetch).
module rom_fetch_bridge
    import rom_fetch_bridge_pkg::*;
#(
    parameter int ROM_AW = ROM_AW_DEFAULT
) (
    input  logic              MCLK,
    input  logic              RESET_N,
    input  logic [ROM_AW-1:0] ROM_ADDR,
    input  logic              ROM_CE_N,
    input  logic              ROM_OE_N,
    input  logic              ROM_WORD,
    input  logic              ROM_INVAL,
    output logic [15:0]       ROM_Q,
    output logic [ROM_AW-2:0] MEM_ADDR,
    output logic              MEM_RD,
    input  logic              MEM_ACK,
    input  logic [15:0]       MEM_DQ,
    output logic              BUSY
);

    localparam int WAW = ROM_AW - 1;

    state_e          state_q;
    logic [15:0]     rom_q_q;
    logic [WAW-1:0]  mem_addr_q;
    logic            mem_rd_q;
    logic            prev_active_q;
    logic [WAW-1:0]  prev_word_q;
    logic            pend_q;       // current access still needs a lookup
    logic            deliver_q;    // fetched word goes to ROM_Q this edge
    logic [15:0]     fetched_q;
    logic            inval_seen_q; // invalidate hit the in-flight fetch

    logic            active_s;
    logic [WAW-1:0]  word_s;
    logic            new_access_s;
    logic            req_s;
    logic            hit_s;
    logic [15:0]     hit_data_s;
    logic            hit0_s;
    logic [15:0]     data0_s;
    logic            wr_en0_s;
    logic            wr_valid_s;

`ifdef ROM_PREFETCH_EN
    logic            mru_q;        // line holding the current demand word
    logic            tgt_q;        // line the in-flight fetch will fill
    logic            hit1_s;
    logic [15:0]     data1_s;
    logic            wr_en1_s;
    logic            hit_idx_s;
`endif

    // Bus decode and hit selection across the buffer lines.
    always_comb begin
        active_s     = !ROM_CE_N && !ROM_OE_N;
        word_s       = ROM_ADDR[ROM_AW-1:1];
        new_access_s = active_s && (!prev_active_q || (word_s != prev_word_q));
        req_s        = active_s && (new_access_s || pend_q);
        wr_valid_s   = !(inval_seen_q || ROM_INVAL);
`ifdef ROM_PREFETCH_EN
        wr_en0_s     = MEM_ACK && (state_q != ST_IDLE) && !tgt_q;
        wr_en1_s     = MEM_ACK && (state_q != ST_IDLE) && tgt_q;
        if (hit0_s) begin
            hit_s      = 1'b1;
            hit_data_s = data0_s;
            hit_idx_s  = 1'b0;
        end else if (hit1_s) begin
            hit_s      = 1'b1;
            hit_data_s = data1_s;
            hit_idx_s  = 1'b1;
        end else begin
            hit_s      = 1'b0;
            hit_data_s = data0_s;
            hit_idx_s  = 1'b0;
        end
`else
        wr_en0_s     = MEM_ACK && (state_q == ST_FETCH);
        hit_s        = hit0_s;
        hit_data_s   = data0_s;
`endif
    end

    rom_line_buf #(.TAG_W(WAW)) u_line0 (
        .clk_i        (MCLK),
        .rst_ni       (RESET_N),
        .inval_i      (ROM_INVAL),
        .wr_en_i      (wr_en0_s),
        .wr_valid_i   (wr_valid_s),
        .wr_tag_i     (mem_addr_q),
        .wr_data_i    (MEM_DQ),
        .lookup_tag_i (word_s),
        .hit_o        (hit0_s),
        .data_o       (data0_s)
    );

`ifdef ROM_PREFETCH_EN
    rom_line_buf #(.TAG_W(WAW)) u_line1 (
        .clk_i        (MCLK),
        .rst_ni       (RESET_N),
        .inval_i      (ROM_INVAL),
        .wr_en_i      (wr_en1_s),
        .wr_valid_i   (wr_valid_s),
        .wr_tag_i     (mem_addr_q),
        .wr_data_i    (MEM_DQ),
        .lookup_tag_i (word_s),
        .hit_o        (hit1_s),
        .data_o       (data1_s)
    );
`endif

    // Fetch FSM with registered ROM_Q, memory request and access tracking.
    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            state_q       <= ST_IDLE;
            rom_q_q       <= 16'h0000;
            mem_addr_q    <= '0;
            mem_rd_q      <= 1'b0;
            prev_active_q <= 1'b0;
            prev_word_q   <= '0;
            pend_q        <= 1'b0;
            deliver_q     <= 1'b0;
            fetched_q     <= 16'h0000;
            inval_seen_q  <= 1'b0;
`ifdef ROM_PREFETCH_EN
            mru_q         <= 1'b0;
            tgt_q         <= 1'b0;
`endif
        end else begin
            prev_active_q <= active_s;
            prev_word_q   <= word_s;
            deliver_q     <= 1'b0;
            if (ROM_INVAL) begin
                inval_seen_q <= 1'b1;
            end
            if (!active_s) begin
                pend_q <= 1'b0;
            end else if (new_access_s) begin
                pend_q <= 1'b1;
            end
            if (deliver_q) begin
                rom_q_q <= lane_sel(fetched_q, ROM_WORD, ROM_ADDR[0]);
            end
            case (state_q)
                ST_IDLE: begin
                    // Lookups wait one cycle while a fetched word is being delivered.
                    if (!deliver_q && req_s) begin
                        pend_q <= 1'b0;
                        if (hit_s) begin
                            rom_q_q <= lane_sel(hit_data_s, ROM_WORD, ROM_ADDR[0]);
`ifdef ROM_PREFETCH_EN
                            mru_q   <= hit_idx_s;
`endif
                        end else begin
                            state_q      <= ST_FETCH;
                            mem_addr_q   <= word_s;
                            mem_rd_q     <= 1'b1;
                            inval_seen_q <= 1'b0;
`ifdef ROM_PREFETCH_EN
                            tgt_q        <= ~mru_q;
                            mru_q        <= ~mru_q;
`endif
                        end
                    end
                end
                ST_FETCH: begin
                    if (MEM_ACK) begin
                        fetched_q <= MEM_DQ;
                        deliver_q <= 1'b1;
`ifdef ROM_PREFETCH_EN
                        // Keep the request up and move on to the next word.
                        state_q      <= ST_PREFETCH;
                        mem_addr_q   <= mem_addr_q + WAW'(1'b1);
                        tgt_q        <= ~tgt_q;
                        inval_seen_q <= 1'b0;
`else
                        state_q   <= ST_IDLE;
                        mem_rd_q  <= 1'b0;
`endif
                    end
                end
`ifdef ROM_PREFETCH_EN
                ST_PREFETCH: begin
                    if (MEM_ACK) begin
                        state_q  <= ST_IDLE;
                        mem_rd_q <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q  <= ST_IDLE;
                    mem_rd_q <= 1'b0;
                end
            endcase
        end
    end

    assign ROM_Q    = rom_q_q;
    assign MEM_ADDR = mem_addr_q;
    assign MEM_RD   = mem_rd_q;
    assign BUSY     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rom_fetch_bridge.sv
// Scoreboard bench for rom_fetch_bridge: expected memory requests and ROM_Q
// values are queued by the stimulus and checked by an independent monitor.
`timescale 1ns/1ps
module tb_rom_fetch_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] rom_addr;
    logic        ce_n, oe_n, rom_word, rom_inval;
    logic [15:0] rom_q;
    logic [22:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [15:0] mem_dq;
    logic        busy;

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } qexp_t;

    qexp_t       rq_q[$];
    logic [22:0] aq_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rd_starts = 0;
    int rd_hi = 0;
    int s;

    rom_fetch_bridge #(.ROM_AW(24)) dut (
        .MCLK      (clk),
        .RESET_N   (rst_n),
        .ROM_ADDR  (rom_addr),
        .ROM_CE_N  (ce_n),
        .ROM_OE_N  (oe_n),
        .ROM_WORD  (rom_word),
        .ROM_INVAL (rom_inval),
        .ROM_Q     (rom_q),
        .MEM_ADDR  (mem_addr),
        .MEM_RD    (mem_rd),
        .MEM_ACK   (mem_ack),
        .MEM_DQ    (mem_dq),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: request starts against the address queue, ROM_Q against stamped values.
    initial begin
        logic        rd_prev;
        logic        ack_prev;
        logic [22:0] ea;
        rd_prev  = 1'b0;
        ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_rd) rd_hi++;
            if (mem_rd && (!rd_prev || ack_prev)) begin
                rd_starts++;
                total++;
                if (aq_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_req: MEM_ADDR=%h, no request expected", mem_addr);
                end else begin
                    ea = aq_q.pop_front();
                    if (mem_addr !== ea) begin
                        bad++;
                        $display("FAIL req_addr: MEM_ADDR=%h want %h", mem_addr, ea);
                    end
                end
            end
            rd_prev  = mem_rd;
            ack_prev = mem_ack;
            if (rq_q.size() != 0 && rq_q[0].cyc == cyc) begin
                total++;
                if (rom_q !== rq_q[0].val) begin
                    bad++;
                    $display("FAIL rom_q@%0d: got %h want %h", cyc, rom_q, rq_q[0].val);
                end
                void'(rq_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [23:0] a, input logic w);
        ce_n = 1'b0; oe_n = 1'b0; rom_addr = a; rom_word = w;
    endtask

    task automatic idle_bus();
        ce_n = 1'b1; oe_n = 1'b1;
    endtask

    task automatic exp_q(input logic [15:0] v);
        rq_q.push_back('{cyc + 1, v});
    endtask

    task automatic wait_rd();
        int n;
        n = 0;
        while (!mem_rd && n < 20) begin
            tick();
            n++;
        end
        chk("rd_wait", {31'd0, mem_rd}, 32'd1);
    endtask

    // Acknowledge the pending request on the w-th cycle of MEM_RD being high.
    task automatic fetch_ack(input logic [15:0] dq, input int w);
        wait_rd();
        repeat (w - 1) tick();
        mem_ack = 1'b1; mem_dq = dq;
        tick();
        mem_ack = 1'b0; mem_dq = 16'h0000;
    endtask

    initial begin
        rst_n = 1'b0; rom_addr = 24'h0; rom_word = 1'b0; rom_inval = 1'b0;
        mem_ack = 1'b0; mem_dq = 16'h0;
        idle_bus();
        tick(); tick();
        chk("rst_rom_q", {16'd0, rom_q}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_mem_addr", {9'd0, mem_addr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

`ifdef ROM_PREFETCH_EN
        // Fetch of the last word, then prefetch wraps to word 0.
        aq_q.push_back(23'h7FFFFF);
        aq_q.push_back(23'h000000);
        rd(24'hFFFFFE, 1'b1);
        fetch_ack(16'h1111, 2);
        exp_q(16'h1111);
        chk("busy_prefetch", {31'd0, busy}, 32'd1);
        fetch_ack(16'h2222, 1);
        tick(); idle_bus(); tick();
        s = rd_starts;
        rd(24'h000000, 1'b0);
        exp_q(16'h2222);
        repeat (3) tick();
        chk("pf_hit_no_rd", s - rd_starts, 32'd0);
        idle_bus(); tick();
        rd(24'hFFFFFF, 1'b0);
        exp_q(16'h1111);
        repeat (3) tick();
        chk("pf_other_line_no_rd", s - rd_starts, 32'd0);
        chk("pf_busy_idle", {31'd0, busy}, 32'd0);
        idle_bus(); tick();
`else
        // Word miss: three cycles of MEM_RD, data one cycle after ACK.
        aq_q.push_back(23'h000008);
        s = rd_hi;
        rd(24'h000010, 1'b1);
        wait_rd();
        chk("busy_fetch", {31'd0, busy}, 32'd1);
        fetch_ack(16'hBEEF, 3);
        exp_q(16'hBEEF);
        chk("rd_high_cycles", rd_hi - s, 32'd3);
        tick();
        chk("busy_idle", {31'd0, busy}, 32'd0);

        // Byte re-read of the buffered word hits, high byte replicated.
        idle_bus(); tick(); tick();
        s = rd_starts;
        rd(24'h000011, 1'b0);
        exp_q(16'hBEBE);
        repeat (3) tick();
        chk("hit_no_rd", rd_starts - s, 32'd0);
        idle_bus(); repeat (3) tick();
        chk("hold_when_idle", {16'd0, rom_q}, 32'h0000BEBE);

        // Address change mid-fetch: first word delivered, then new request.
        aq_q.push_back(23'h000020);
        aq_q.push_back(23'h000100);
        rd(24'h000040, 1'b1);
        wait_rd();
        rom_addr = 24'h000200;
        fetch_ack(16'h1234, 3);
        exp_q(16'h1234);
        fetch_ack(16'h5678, 2);
        exp_q(16'h5678);
        tick(); idle_bus(); tick();
        s = rd_starts;
        rd(24'h000201, 1'b0);
        exp_q(16'h5656);
        repeat (2) tick();
        chk("second_word_hit", rd_starts - s, 32'd0);

        // Invalidate while idle: the buffered word must be refetched.
        idle_bus();
        rom_inval = 1'b1; tick(); rom_inval = 1'b0; tick();
        aq_q.push_back(23'h000100);
        rd(24'h000200, 1'b1);
        fetch_ack(16'hCAFE, 2);
        exp_q(16'hCAFE);
        tick(); idle_bus(); tick();

        // Invalidate during a fetch: data delivered but not kept.
        aq_q.push_back(23'h000040);
        rd(24'h000080, 1'b1);
        wait_rd();
        rom_inval = 1'b1; tick(); rom_inval = 1'b0;
        fetch_ack(16'hA5A5, 2);
        exp_q(16'hA5A5);
        tick(); idle_bus(); tick();
        aq_q.push_back(23'h000040);
        rd(24'h000080, 1'b1);
        fetch_ack(16'h0F0F, 2);
        exp_q(16'h0F0F);
        tick(); idle_bus(); tick();

        // Top word: no follow-on request without prefetch.
        aq_q.push_back(23'h7FFFFF);
        s = rd_starts;
        rd(24'hFFFFFE, 1'b1);
        fetch_ack(16'h1357, 2);
        exp_q(16'h1357);
        repeat (4) tick();
        chk("top_word_single_req", rd_starts - s, 32'd1);
        chk("top_word_busy", {31'd0, busy}, 32'd0);
        idle_bus(); tick();
`endif

        // Reset mid-fetch, then a stray ACK that must be ignored.
        aq_q.push_back(23'h000080);
        rd(24'h000100, 1'b1);
        wait_rd();
        rst_n = 1'b0; idle_bus();
        tick();
        chk("midrst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("midrst_rom_q", {16'd0, rom_q}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_mem_addr", {9'd0, mem_addr}, 32'd0);
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_dq = 16'hDEAD;
        tick();
        mem_ack = 1'b0; mem_dq = 16'h0000;
        tick(); tick();
        chk("late_ack_rom_q", {16'd0, rom_q}, 32'd0);
        chk("late_ack_busy", {31'd0, busy}, 32'd0);
        chk("late_ack_mem_rd", {31'd0, mem_rd}, 32'd0);
        aq_q.push_back(23'h000080);
        rd(24'h000100, 1'b1);
        fetch_ack(16'h7777, 2);
        exp_q(16'h7777);
        tick(); idle_bus(); repeat (6) tick();

        chk("req_queue_drained", aq_q.size(), 32'd0);
        chk("romq_queue_drained", rq_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
